// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done and operand/result bundle for serial_subtractor
// Optional ovf signal is present only when SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
`ifdef SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
`ifdef SUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b, LSB first, with start/busy/done handshake
// Optional signed-overflow flag guarded by SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nx;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             bo;
    logic             last_bit;
`ifdef SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // Full-subtractor cell on the current LSBs plus the result shift value it produces
    always_comb begin
        d_bit            = a_sh[0] ^ b_sh[0] ^ br;
        bo               = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        res_nx           = res_sh >> 1;
        res_nx[WIDTH-1]  = d_bit;
        last_bit         = (cnt == CW'(WIDTH - 1));
    end

    // State register; async reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: start is honoured only when not running, so DONE can chain straight into RUN
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last_bit) state_nx = DONE;
            DONE:    state_nx = bus.start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: capture on accept, one bit per clock while running, publish results on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            bus.diff   <= '0;
            bus.borrow <= 1'b0;
`ifdef SUB_OVF_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            bus.ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        res_sh <= '0;
                        br     <= 1'b0;
                        cnt    <= '0;
`ifdef SUB_OVF_EN
                        // Operand sign bits are shifted out during RUN, so keep copies
                        a_msb  <= bus.a[WIDTH-1];
                        b_msb  <= bus.b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_nx;
                    br     <= bo;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        bus.diff   <= res_nx;
                        bus.borrow <= bo;
`ifdef SUB_OVF_EN
                        bus.ovf    <= (a_msb != b_msb) && (res_nx[WIDTH-1] != a_msb);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor (WIDTH=8)
// Ovf checks are compiled in when SUB_OVF_EN is defined.
module tb_serial_subtractor;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    int   lat;
    int   pulses;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs are driven and outputs sampled at the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic launch(input logic [7:0] av, input logic [7:0] bv);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // n counts clocks since the start edge (start edge = 1); bounded wait for done
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (bus.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] ed, input logic eb);
        launch(av, bv);
        check({tag, "_busy"}, bus.busy, 1);
        wait_done(1, lat);
        check({tag, "_lat"}, lat, WIDTH + 1);
        check({tag, "_diff"}, bus.diff, ed);
        check({tag, "_borrow"}, bus.borrow, eb);
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_diff", bus.diff, 0);
        check("rst_borrow", bus.borrow, 0);
`ifdef SUB_OVF_EN
        check("rst_ovf", bus.ovf, 0);
`endif
        rst_n = 1'b1;
        tick();

        // 1: small positive difference
        op("t1", 8'h05, 8'h03, 8'h02, 1'b0);
`ifdef SUB_OVF_EN
        check("t1_ovf", bus.ovf, 0);
`endif
        tick();
        check("t1_done_once", bus.done, 0);
        check("t1_idle", bus.busy, 0);

        // 2: negative result wraps and borrows
        op("t2", 8'h03, 8'h05, 8'hFE, 1'b1);
`ifdef SUB_OVF_EN
        check("t2_ovf", bus.ovf, 0);
`endif
        tick();

        // 3: -128 - 1 overflows in signed terms
        op("t3", 8'h80, 8'h01, 8'h7F, 1'b0);
`ifdef SUB_OVF_EN
        check("t3_ovf", bus.ovf, 1);
`endif
        tick();

        // 3b: 127 - (-1) overflows the other way, with unsigned borrow
        op("t3b", 8'h7F, 8'hFF, 8'h80, 1'b1);
`ifdef SUB_OVF_EN
        check("t3b_ovf", bus.ovf, 1);
`endif
        tick();

        // 4: start while busy must be ignored
        launch(8'hFF, 8'h00);
        tick();
        tick();
        check("t4_hold_diff", bus.diff, 8'h80);
        bus.a     = 8'h00;
        bus.b     = 8'h01;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t4_still_busy", bus.busy, 1);
        wait_done(4, lat);
        check("t4_lat", lat, WIDTH + 1);
        check("t4_diff", bus.diff, 8'hFF);
        check("t4_borrow", bus.borrow, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done === 1'b1) pulses++;
        end
        check("t4_no_extra_done", pulses, 0);
        check("t4_idle", bus.busy, 0);

        // 5: asynchronous reset mid-operation
        launch(8'h10, 8'h20);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_done", bus.done, 0);
        check("t5_rst_diff", bus.diff, 0);
        check("t5_rst_borrow", bus.borrow, 0);
        tick();
        rst_n = 1'b1;
        tick();
        op("t5", 8'h00, 8'h00, 8'h00, 1'b0);
`ifdef SUB_OVF_EN
        check("t5_ovf", bus.ovf, 0);
`endif
        tick();

        // 6: start accepted in the done cycle; previous result held through the run
        op("t6a", 8'h05, 8'h03, 8'h02, 1'b0);
        launch(8'h0A, 8'h0B);
        check("t6_busy", bus.busy, 1);
        check("t6_done_low", bus.done, 0);
        tick();
        tick();
        tick();
        check("t6_hold_diff", bus.diff, 8'h02);
        check("t6_hold_borrow", bus.borrow, 0);
        wait_done(4, lat);
        check("t6_lat", lat, WIDTH + 1);
        check("t6_diff", bus.diff, 8'hFF);
        check("t6_borrow", bus.borrow, 1);
        tick();
        check("t6_idle_done", bus.done, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
